// File: rtl/sumres_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding,
// operation codes and datapath width.
package sumres_pkg;

  localparam int WIDTH = 4;

  localparam logic OP_SUMA  = 1'b0;
  localparam logic OP_RESTA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/compl1.sv
// Conditional ones' complement of a 4-bit word: q = cpl ? ~d : d.
module compl1
  import sumres_pkg::*;
(
  input  logic [WIDTH-1:0] d,
  input  logic             cpl,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign q[gi] = d[gi] ^ cpl;
    end
  endgenerate

endmodule

// File: rtl/sumres_serie_sumador_completo.sv
// One-bit full adder used by the serial datapath.
module sumador_completo (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ cin;
  assign carry = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/sumres_serie.sv
// Bit-serial 4-bit adder/subtractor: operands shift LSB-first through one
// full adder; subtraction uses ones' complement of B plus carry-in = 1.
module sumres_serie
  import sumres_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  state_t           state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] ra_reg, ra_next;
  logic [WIDTH-1:0] rb_reg, rb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             c_reg, c_next;
  logic             c3_reg, c3_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             zero_reg, zero_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] b_cpl;
  logic             fa_sum, fa_carry;

  compl1 u_compl1 (
    .d   (b),
    .cpl (op),
    .q   (b_cpl)
  );

  sumador_completo u_fa (
    .x     (ra_reg[0]),
    .y     (rb_reg[0]),
    .cin   (c_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ra_next    = ra_reg;
    rb_next    = rb_reg;
    acc_next   = acc_reg;
    c_next     = c_reg;
    c3_next    = c3_reg;
    s_next     = s_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          ra_next    = a;
          rb_next    = b_cpl;
          c_next     = op;
          cnt_next   = 2'd0;
          state_next = CALC;
        end
      end
      CALC: begin
        acc_next = {fa_sum, acc_reg[WIDTH-1:1]};
        ra_next  = ra_reg >> 1;
        rb_next  = rb_reg >> 1;
        c_next   = fa_carry;
        // Carry produced by bit 2 is the carry into the MSB, needed for ovf.
        if (cnt_reg == 2'd2) begin
          c3_next = fa_carry;
        end
        if (cnt_reg == 2'd3) begin
          s_next     = acc_next;
          cout_next  = fa_carry;
          ovf_next   = c3_reg ^ fa_carry;
          zero_next  = (acc_next == '0);
          state_next = FIN;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      acc_reg   <= '0;
      c_reg     <= 1'b0;
      c3_reg    <= 1'b0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ra_reg    <= ra_next;
      rb_reg    <= rb_next;
      acc_reg   <= acc_next;
      c_reg     <= c_next;
      c3_reg    <= c3_next;
      s_reg     <= s_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign s    = s_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_sumres_serie.sv
// Directed bench for sumres_serie with hand-computed expected results.
module tb_sumres_serie;
  import sumres_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       op = OP_SUMA;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, cout, ovf, zero;
  logic [3:0] s;

  int n_checks = 0;
  int n_pass   = 0;

  sumres_serie dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_done"}, {7'd0, done}, 8'd0);
    check({tag, "_s"},    {4'd0, s},    8'd0);
    check({tag, "_cout"}, {7'd0, cout}, 8'd0);
    check({tag, "_ovf"},  {7'd0, ovf},  8'd0);
    check({tag, "_zero"}, {7'd0, zero}, 8'd1);
  endtask

  // Start at edge k, expect done/results exactly after edge k+4, idle after k+5.
  task automatic do_op(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                       input logic opi, input logic [3:0] es, input logic ec,
                       input logic eo, input logic ez);
    @(negedge clk);
    a = ai; b = bi; op = opi; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_k"}, {7'd0, busy}, 8'd1);
    @(negedge clk);
    start = 1'b0;
    a = ~ai; b = ~bi; op = ~opi;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_k3"}, {7'd0, done}, 8'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_busy"}, {7'd0, busy}, 8'd1);
    check({tag, "_s"},    {4'd0, s},    {4'd0, es});
    check({tag, "_cout"}, {7'd0, cout}, {7'd0, ec});
    check({tag, "_ovf"},  {7'd0, ovf},  {7'd0, eo});
    check({tag, "_zero"}, {7'd0, zero}, {7'd0, ez});
    $display("op %s a=%b b=%b op=%b -> s=%b cout=%b ovf=%b zero=%b",
             tag, ai, bi, opi, s, cout, ovf, zero);
    @(posedge clk); #1;
    check({tag, "_done_k5"}, {7'd0, done}, 8'd0);
    check({tag, "_busy_k5"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    int         ndone;
    logic [3:0] s_cap;
    logic       ovf_cap;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    do_op("add",      4'b0011, 4'b0101, OP_SUMA,  4'b1000, 1'b0, 1'b1, 1'b0);
    do_op("sub_nb",   4'b0101, 4'b0011, OP_RESTA, 4'b0010, 1'b1, 1'b0, 1'b0);
    do_op("sub_b",    4'b0011, 4'b0101, OP_RESTA, 4'b1110, 1'b0, 1'b0, 1'b0);

    // Results hold while idle even though inputs move.
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; op = OP_SUMA;
    repeat (3) @(posedge clk);
    #1;
    check("hold_s", {4'd0, s}, 8'b1110);
    $display("hold s=%b", s);

    // Reset sampled at bit edge 2 aborts the operation.
    @(negedge clk);
    a = 4'b0111; b = 4'b0001; op = OP_SUMA; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_ndone", ndone[7:0], 8'd0);
    $display("midrst done_pulses=%0d s=%b", ndone, s);

    do_op("wrap",     4'b1000, 4'b1000, OP_SUMA,  4'b0000, 1'b1, 1'b1, 1'b1);

    // Reset and start on the same edge: nothing captured.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 4'b0001; b = 4'b0001;
    @(posedge clk); #1;
    check_reset_outputs("rst_start");
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_busy1", {7'd0, busy}, 8'd0);
    $display("rst_start busy=%b", busy);

    // start held through CALC/FIN with new operands: ignored until IDLE.
    @(negedge clk);
    a = 4'b0111; b = 4'b0001; op = OP_SUMA; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'b0001; b = 4'b0001;
    ndone = 0; s_cap = '0; ovf_cap = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        s_cap = s;
        ovf_cap = ovf;
      end
    end
    check("ign_ndone", ndone[7:0], 8'd1);
    check("ign_s",     {4'd0, s_cap}, 8'b1000);
    check("ign_ovf",   {7'd0, ovf_cap}, 8'd1);
    check("ign_busy_k5", {7'd0, busy}, 8'd0);
    $display("ign first s=%b ovf=%b done_pulses=%0d", s_cap, ovf_cap, ndone);
    @(posedge clk); #1;
    check("ign_busy_k6", {7'd0, busy}, 8'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ign2_done", {7'd0, done}, 8'd1);
    check("ign2_s",    {4'd0, s},    8'b0010);
    check("ign2_ovf",  {7'd0, ovf},  8'd0);
    $display("ign second s=%b cout=%b ovf=%b", s, cout, ovf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
